// File: rtl/i2c_target_resp_if.sv
// Bus and register-port bundle for the I2C target responder.
//   i2c_scl_i / i2c_sda_i : raw (asynchronous) pin levels seen by the target
//   i2c_sda_o / i2c_sda_e : open-drain SDA output value and pull-low enable
//   reg_*                 : byte-addressed register port (pointer, write strobe/data,
//                           read request and read data returned one cycle later)
//   i2c_status            : {5'b0, rd_mode, addr_match, busy}
// The slave modport is used by the target; the master modport by whatever models the bus
// and the register file.
interface i2c_target_resp_if;
    logic       i2c_scl_i;
    logic       i2c_sda_i;
    logic       i2c_sda_o;
    logic       i2c_sda_e;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic [7:0] i2c_status;

    modport slave (
        input  i2c_scl_i, i2c_sda_i, reg_rdata,
        output i2c_sda_o, i2c_sda_e, reg_addr, reg_wdata, reg_wr, reg_rd, i2c_status
    );

    modport master (
        output i2c_scl_i, i2c_sda_i, reg_rdata,
        input  i2c_sda_o, i2c_sda_e, reg_addr, reg_wdata, reg_wr, reg_rd, i2c_status
    );
endinterface

// File: rtl/i2c_target_resp.sv
// I2C target responder emulating a register-mapped device.
// Oversamples SCL/SDA, glitch-filters them, detects START/STOP, matches a 7-bit address and
// ACKs bytes. Writes: first byte sets the register pointer, following bytes pulse reg_wr.
// Reads: reg_rd fetches a byte (reg_rdata valid the next cycle) which is shifted out MSB
// first; the pointer auto-increments with 8-bit wrap.
// Ports:
//   clk   : system clock (>= 20x SCL)
//   reset : synchronous active-high reset
//   bus   : i2c_target_resp_if.slave (pins, register port, status)
module i2c_target_resp #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    i2c_target_resp_if.slave bus
);
    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdMack,
        StIgnore
    } state_e;

    // Index 0 = SCL, index 1 = SDA.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      filt_q, filt_d;
    logic [1:0]      prev_q;
    logic [CntW-1:0] fcnt_q [2];
    logic [CntW-1:0] fcnt_d [2];

    // A new level is accepted only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (32'(fcnt_q[i]) + 32'd1 >= FILTER_LEN) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Lines reset to the idle-high level so leaving reset on an idle bus creates no edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            fcnt_q  <= '{default: '0};
        end else begin
            sync1_q <= {bus.i2c_sda_i, bus.i2c_scl_i};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            fcnt_q  <= fcnt_d;
        end
    end

    logic sda_f;
    logic scl_rise, scl_fall, start_ev, stop_ev;

    assign sda_f    = filt_q[1];
    assign scl_rise = filt_q[0] & ~prev_q[0];
    assign scl_fall = ~filt_q[0] & prev_q[0];
    assign start_ev = prev_q[1] & ~filt_q[1] & filt_q[0] & prev_q[0];
    assign stop_ev  = ~prev_q[1] & filt_q[1] & filt_q[0] & prev_q[0];

    state_e     state_q, state_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       rd_dly_q;
    logic       sda_e_q, sda_e_d;
    logic       busy_q, busy_d;
    logic       match_q, match_d;
    logic       rdmode_q, rdmode_d;

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       rx_state;

    assign rx_byte   = {rx_q[6:0], sda_f};
    assign rx_state  = (state_q == StAddr) || (state_q == StPtr) || (state_q == StWdata);
    assign byte_done = rx_state && scl_rise && (bcnt_q == 4'd7);

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        ptr_d    = ptr_q;
        wdata_d  = wdata_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        sda_e_d  = sda_e_q;
        busy_d   = busy_q;
        match_d  = match_q;
        rdmode_d = rdmode_q;

        // Pointer advances the cycle after the write strobe.
        if (wr_q) begin
            ptr_d = ptr_q + 8'd1;
        end

        if (start_ev) begin
            state_d  = StAddr;
            bcnt_d   = 4'd0;
            sda_e_d  = 1'b0;
            busy_d   = 1'b1;
            match_d  = 1'b0;
            rdmode_d = 1'b0;
        end else if (stop_ev) begin
            state_d  = StIdle;
            bcnt_d   = 4'd0;
            sda_e_d  = 1'b0;
            busy_d   = 1'b0;
            match_d  = 1'b0;
            rdmode_d = 1'b0;
        end else begin
            if (rx_state && scl_rise) begin
                rx_d   = rx_byte;
                bcnt_d = byte_done ? 4'd0 : bcnt_q + 4'd1;
            end

            case (state_q)
                StAddr: begin
                    if (byte_done) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            match_d  = 1'b1;
                            rdmode_d = rx_byte[0];
                            rd_d     = rx_byte[0];
                            state_d  = StAddrAck;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                StPtr: begin
                    if (byte_done) begin
                        ptr_d   = rx_byte;
                        state_d = StPtrAck;
                    end
                end
                StWdata: begin
                    if (byte_done) begin
                        wr_d    = 1'b1;
                        wdata_d = rx_byte;
                        state_d = StWdataAck;
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    // bcnt 0: waiting for the fall that ends bit 8; 1: waiting for the 9th.
                    if (scl_fall) begin
                        if (bcnt_q == 4'd0) begin
                            sda_e_d = 1'b1;
                            bcnt_d  = 4'd1;
                        end else begin
                            sda_e_d = 1'b0;
                            bcnt_d  = 4'd0;
                            if (state_q == StAddrAck && rdmode_q) begin
                                sda_e_d = ~tx_q[7];
                                tx_d    = {tx_q[6:0], 1'b0};
                                state_d = StRdata;
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bcnt_q == 4'd8) begin
                            sda_e_d = 1'b0;
                            bcnt_d  = 4'd0;
                            state_d = StRdMack;
                        end else begin
                            sda_e_d = ~tx_q[7];
                            tx_d    = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                StRdMack: begin
                    if (scl_rise && bcnt_q == 4'd0) begin
                        ptr_d = ptr_q + 8'd1;
                        if (!sda_f) begin
                            rd_d   = 1'b1;
                            bcnt_d = 4'd1;
                        end else begin
                            state_d = StIgnore;
                        end
                    end else if (scl_fall && bcnt_q == 4'd1) begin
                        sda_e_d = ~tx_q[7];
                        tx_d    = {tx_q[6:0], 1'b0};
                        bcnt_d  = 4'd0;
                        state_d = StRdata;
                    end
                end
                default: begin
                end
            endcase
        end

        // Read data arrives the cycle after reg_rd.
        if (rd_dly_q) begin
            tx_d = bus.reg_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            bcnt_q   <= 4'd0;
            rx_q     <= 8'h00;
            tx_q     <= 8'h00;
            ptr_q    <= 8'h00;
            wdata_q  <= 8'h00;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            rd_dly_q <= 1'b0;
            sda_e_q  <= 1'b0;
            busy_q   <= 1'b0;
            match_q  <= 1'b0;
            rdmode_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            ptr_q    <= ptr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rd_dly_q <= rd_q;
            sda_e_q  <= sda_e_d;
            busy_q   <= busy_d;
            match_q  <= match_d;
            rdmode_q <= rdmode_d;
        end
    end

    // START/STOP release SDA in the very cycle they are detected.
    assign bus.i2c_sda_o  = 1'b0;
    assign bus.i2c_sda_e  = sda_e_q & ~(start_ev | stop_ev);
    assign bus.reg_addr   = ptr_q;
    assign bus.reg_wdata  = wdata_q;
    assign bus.reg_wr     = wr_q;
    assign bus.reg_rd     = rd_q;
    assign bus.i2c_status = {5'b0, rdmode_q, match_q, busy_q};
endmodule

// File: tb/tb_i2c_target_resp.sv
// Self-checking bench for i2c_target_resp: bit-banged I2C master over an open-drain SDA,
// a register-file model returning ~reg_addr, and a scoreboard of expected register-port
// events compared against the events the DUT produces.
module tb_i2c_target_resp;
    localparam int Q = 10;  // clocks per quarter SCL period

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    always #5 clk = ~clk;

    i2c_target_resp_if bus ();

    i2c_target_resp #(
        .SLAVE_ADDR (7'h50),
        .FILTER_LEN (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.i2c_scl_i = m_scl;
    assign bus.i2c_sda_i = m_sda & ~bus.i2c_sda_e;

    always @(posedge clk) begin
        if (bus.reg_rd) bus.reg_rdata <= ~bus.reg_addr;
    end

    int n_checks = 0;
    int n_pass = 0;

    // Scoreboard entries: {kind(1=wr,2=rd,3=both), addr, data}
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];

    always @(negedge clk) begin
        if (!reset && (bus.reg_wr || bus.reg_rd)) begin
            obs_q.push_back({(bus.reg_wr && bus.reg_rd) ? 2'd3 : (bus.reg_wr ? 2'd1 : 2'd2),
                             bus.reg_addr, bus.reg_wr ? bus.reg_wdata : 8'h00});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b1; wait_clks(Q);
    endtask

    // One SCL clock; optional 2-cycle low glitch in the high phase.
    task automatic bit_xfer(input logic b, input logic glitch, output logic line);
        m_sda = b; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        if (glitch) begin
            m_scl = 1'b0; wait_clks(2);
            m_scl = 1'b1;
        end
        wait_clks(Q);
        line = bus.i2c_sda_i;
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic ack);
        logic line;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], glitch && (i == 7), line);
        bit_xfer(1'b1, 1'b0, line);
        ack = ~line;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic line;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, line);
            b[i] = line;
        end
        bit_xfer(mack, 1'b0, line);
    endtask

    task automatic drain(input string name);
        logic [17:0] e;
        wait_clks(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) check({name, " missing_event"}, 32'hFFFF_FFFF, 32'(e));
            else check({name, " event"}, 32'(obs_q.pop_front()), 32'(e));
        end
        check({name, " extra_events"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    typedef struct {
        string      name;
        logic [7:0] addr_byte;
        logic [7:0] ptr;
        int         ndata;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       glitch;
        logic       exp_ack;
    } wr_vec_t;

    wr_vec_t vecs [4];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish within 2 ms");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        logic [7:0] a;

        vecs[0] = '{"burst",  8'hA0, 8'h10, 2, 8'h5A, 8'hC3, 1'b0, 1'b1};
        vecs[1] = '{"miss",   8'hA2, 8'h33, 0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{"wrap",   8'hA0, 8'hFF, 2, 8'h11, 8'h22, 1'b0, 1'b1};
        vecs[3] = '{"glitch", 8'hA0, 8'h40, 1, 8'h99, 8'h00, 1'b1, 1'b1};

        wait_clks(5);
        check("rst sda_e", bus.i2c_sda_e, 0);
        check("rst sda_o", bus.i2c_sda_o, 0);
        check("rst reg_wr", bus.reg_wr, 0);
        check("rst reg_rd", bus.reg_rd, 0);
        check("rst reg_addr", bus.reg_addr, 0);
        check("rst reg_wdata", bus.reg_wdata, 0);
        check("rst status", bus.i2c_status, 0);
        reset = 1'b0;
        wait_clks(10);

        for (int v = 0; v < 4; v++) begin
            a = vecs[v].ptr;
            if (vecs[v].exp_ack) begin
                for (int i = 0; i < vecs[v].ndata; i++) begin
                    exp_q.push_back({2'd1, a, (i == 0) ? vecs[v].d0 : vecs[v].d1});
                    a = a + 8'd1;
                end
            end
            i2c_start();
            check({vecs[v].name, " busy_after_start"}, bus.i2c_status, 1);
            write_byte(vecs[v].addr_byte, 1'b0, ack);
            check({vecs[v].name, " addr_ack"}, ack, vecs[v].exp_ack);
            check({vecs[v].name, " status"}, bus.i2c_status, {vecs[v].exp_ack, 1'b1});
            write_byte(vecs[v].ptr, vecs[v].glitch, ack);
            check({vecs[v].name, " ptr_ack"}, ack, vecs[v].exp_ack);
            for (int i = 0; i < vecs[v].ndata; i++) begin
                write_byte((i == 0) ? vecs[v].d0 : vecs[v].d1, 1'b0, ack);
                check({vecs[v].name, " data_ack"}, ack, vecs[v].exp_ack);
            end
            i2c_stop();
            wait_clks(Q);
            check({vecs[v].name, " status_after_stop"}, bus.i2c_status, 0);
            drain(vecs[v].name);
        end

        // Random read: pointer 0x20, repeated START, two bytes (ACK then NACK).
        exp_q.push_back({2'd2, 8'h20, 8'h00});
        exp_q.push_back({2'd2, 8'h21, 8'h00});
        i2c_start();
        write_byte(8'hA0, 1'b0, ack);
        write_byte(8'h20, 1'b0, ack);
        check("read ptr_ack", ack, 1);
        i2c_start();
        write_byte(8'hA1, 1'b0, ack);
        check("read addr_ack", ack, 1);
        check("read status", bus.i2c_status, 8'h07);
        read_byte(1'b0, rb);
        check("read byte0", rb, 8'hDF);
        read_byte(1'b1, rb);
        check("read byte1", rb, 8'hDE);
        check("read sda_e_after_nack", bus.i2c_sda_e, 0);
        i2c_stop();
        wait_clks(Q);
        check("read status_after_stop", bus.i2c_status, 0);
        drain("read");

        // Abort mid-byte, then a complete write to the same pointer.
        i2c_start();
        write_byte(8'hA0, 1'b0, ack);
        write_byte(8'h05, 1'b0, ack);
        for (int i = 0; i < 4; i++) bit_xfer(i[0], 1'b0, ack);
        i2c_stop();
        wait_clks(Q);
        check("abort status", bus.i2c_status, 0);
        check("abort sda_e", bus.i2c_sda_e, 0);
        drain("abort");
        exp_q.push_back({2'd1, 8'h05, 8'h77});
        i2c_start();
        write_byte(8'hA0, 1'b0, ack);
        write_byte(8'h05, 1'b0, ack);
        write_byte(8'h77, 1'b0, ack);
        check("recover data_ack", ack, 1);
        i2c_stop();
        drain("recover");

        // Reset while the target drives a 0 (first bit of ~0x80 = 0x7F).
        exp_q.push_back({2'd2, 8'h80, 8'h00});
        i2c_start();
        write_byte(8'hA0, 1'b0, ack);
        write_byte(8'h80, 1'b0, ack);
        i2c_start();
        write_byte(8'hA1, 1'b0, ack);
        check("rstmid sda_e_driving", bus.i2c_sda_e, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid sda_e", bus.i2c_sda_e, 0);
        check("rstmid status", bus.i2c_status, 0);
        wait_clks(3);
        reset = 1'b0;
        m_sda = 1'b1;
        m_scl = 1'b1;
        wait_clks(2 * Q);
        drain("rstmid");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/i2c_target_resp.md
# i2c_target_resp

I2C target (slave) responder: the bus-side counterpart of the team's I2C master controller, used in simulation and on-board to emulate a register-mapped I2C device (e.g. a QSFP/EEPROM model). Oversamples SCL/SDA on the system clock, filters glitches, detects START/STOP, matches a 7-bit address, and acknowledges bytes. On writes it delivers the bytes to a byte-addressed register port; on reads it returns bytes from that port, with an auto-incrementing register pointer.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit target address matched against the first byte after START
- FILTER_LEN, 3, consecutive identical samples required to accept a new SCL/SDA level (≥1)
- clk  in  1  system clock; ≥20× SCL frequency
- reset  in  1  synchronous, active-high reset
- i2c_scl_i  in  1  SCL pin input (asynchronous)
- i2c_sda_i  in  1  SDA pin input (asynchronous)
- i2c_sda_o  out  1  constant 0 (open-drain data value)
- i2c_sda_e  out  1  1 = pull SDA low
- reg_addr  out  8  register pointer
- reg_wdata  out  8  write data, valid with reg_wr
- reg_wr  out  1  1-cycle write strobe
- reg_rd  out  1  1-cycle read request at reg_addr
- reg_rdata  in  8  read data; valid the cycle after reg_rd
- i2c_status  out  8  {5'b0, rd_mode, addr_match, busy}

## Operation
- Input path: 2-flop synchronizer per line, then filter; filtered level changes only after FILTER_LEN agreeing samples. scl_rise/scl_fall/sda edges are 1-cycle events from the filtered levels.
- START: filtered SDA falls while SCL high; STOP: SDA rises while SCL high. Both take priority over everything and are legal in any state; START (incl. repeated) → ADDR with bit counter cleared; STOP → IDLE. Either releases sda_e in the same cycle.
- Data sampled on scl_rise, MSB first; target drives SDA only in the cycle after scl_fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
- ADDR: 8th scl_rise → byte[7:1]==SLAVE_ADDR: addr_match=1, rd_mode=byte[0], go ADDR_ACK; else IGNORE (sda_e=0 until START/STOP).
- *_ACK states: sda_e=1 from the scl_fall after the 8th bit to the scl_fall after the 9th bit.
- Write (rd_mode=0): first byte → reg_addr (PTR); each following byte: on its 8th scl_rise, reg_wr pulses for 1 cycle with reg_wdata=byte, reg_addr=pointer; pointer += 1 on the following cycle, 8-bit wrap 0xFF→0x00.
- Read (rd_mode=1): reg_rd pulses on the address byte's 8th scl_rise; reg_rdata loaded into shift register next cycle. Bit n driven at scl_fall ending the previous bit (first bit at scl_fall ending ADDR_ACK): sda_e = ~bit. After 8 bits, sda_e=0 at scl_fall; RD_MACK samples SDA on 9th scl_rise; pointer += 1 (wrap). SDA=0 (ACK) → reg_rd at new pointer, next byte; SDA=1 (NACK) → IGNORE.
- busy=1 from START to STOP regardless of match; addr_match and rd_mode cleared on START/STOP.
- Incomplete bytes (START/STOP mid-byte) produce no reg_wr and no pointer change.

## Timing
- Reset values: i2c_sda_e=0, i2c_sda_o=0, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0, i2c_status=0; state IDLE. Reset mid-transfer releases SDA on the next clk.
- Pin-to-event latency: 2 + FILTER_LEN cycles; pulses shorter than FILTER_LEN cycles ignored.
- sda_e change occurs 1 cycle after the scl_fall event (hold time = (3+FILTER_LEN) clks after pin edge).
- reg_wr: 1 cycle after 8th scl_rise event; reg_rd→reg_rdata capture: 1 cycle; both never asserted in the same cycle.
- START and STOP in the same cycle impossible (single SDA edge); START in same cycle as scl_rise: START wins, bit discarded.

## Test plan
- Write burst: START, 0xA0, 0x10, 0x5A, 0xC3, STOP → SDA low in 9th clock of all 4 bytes; reg_wr twice: (0x10,0x5A), (0x11,0xC3); busy 1 during, 0 after STOP.
- Address miss: START, 0xA2, 0x33, STOP → SDA high in 9th clocks, no reg_wr/reg_rd, addr_match=0, busy=1 until STOP.
- Random read: START 0xA0 0x20, repeated START 0xA1, read 2 bytes (model reg_rdata = ~reg_addr), master ACK then NACK, STOP → bytes 0xDF, 0xDE on SDA; reg_rd exactly at 0x20, 0x21; sda_e=0 after NACK; rd_mode=1 during read.
- Pointer wrap: START 0xA0 0xFF 0x11 0x22 STOP → reg_wr at 0xFF then 0x00.
- Abort: START 0xA0 0x05, 4 data bits then STOP → no reg_wr, state IDLE, sda_e=0; then valid write to 0x05 works.
- Glitch/reset: 2-cycle SCL low pulse (FILTER_LEN=3) → no bit counted; reset asserted while driving a 0 in RDATA → sda_e=0 next cycle, status=0.
